ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter; the sending end of the keyboard link read by OperationEncoder.
//  Sends one command byte to the keyboard, e.g. 0xFF reset, 0xED LED set, 0xF4 enable.
//  Drives PS2_CLK/PS2_DATA as open-drain through output enables; the top-level tristates are
//  PS2_CLK = clk_oe ? 1'b0 : 1'bz and PS2_DATA = data_oe ? 1'b0 : 1'bz.
//  busy tells the receiver to ignore line activity while a command is being sent.
// PARAMETERS
//  INHIBIT_CYCLES  10000     clk cycles PS2_CLK is held low before request-to-send (100 us @ 100 MHz)
//  TIMEOUT_CYCLES  2000000   max clk cycles between device clock falling edges (20 ms @ 100 MHz)
//  SYNC_STAGES     2         flip-flop synchronizer depth on ps2_clk_i and ps2_data_i (>=2)
// PORTS
//  clk        in   1  system clock, 100 MHz
//  rst        in   1  asynchronous, active-high reset
//  tx_valid   in   1  command byte available
//  tx_data    in   8  command byte
//  tx_ready   out  1  block can accept a byte (high only in IDLE)
//  ps2_clk_i  in   1  sampled PS2_CLK pad
//  ps2_data_i in   1  sampled PS2_DATA pad
//  clk_oe     out  1  1 = pull PS2_CLK low
//  data_oe    out  1  1 = pull PS2_DATA low
//  busy       out  1  high in every state except IDLE
//  tx_done    out  1  one-cycle pulse: byte acknowledged by device
//  tx_err     out  1  one-cycle pulse: NACK or timeout
// BEHAVIOUR
//  Reset: state=IDLE; tx_ready=1; clk_oe, data_oe, busy, tx_done, tx_err = 0; counters = 0.
//   Reset asserted mid-transfer releases both lines immediately.
//  Input conditioning: both pads pass through SYNC_STAGES flip-flops.
//   fall = synchronized clk was 1 last cycle and is 0 now.
//  Handshake: a byte is accepted when tx_valid && tx_ready.
//   On acceptance, latch tx_data and parity = ~^tx_data (odd parity), then enter INHIBIT next cycle.
//   tx_valid is ignored whenever tx_ready=0.
//  INHIBIT: clk_oe=1 and data_oe=0 for exactly INHIBIT_CYCLES cycles.
//   On the last cycle, assert data_oe=1 (start bit) and go to RTS.
//  RTS: clk_oe=0 and data_oe=1. Wait for fall.
//   On that fall, drive data bit0 and set bitcnt=1. Go to SHIFT.
//  SHIFT: on each fall, update the driven bit:
//   - bitcnt 1..7 -> data bit[bitcnt]
//   - bitcnt 8    -> parity
//   - bitcnt 9    -> release (stop bit = 1)
//   bitcnt increments on each fall. After the bitcnt 9 fall, go to ACK.
//   Bit encoding: bit value 0 -> data_oe=1; bit value 1 -> data_oe=0.
//  ACK: clk_oe=0, data_oe=0. On the next fall, sample the data line.
//   - 0 -> go to WAIT_IDLE.
//   - 1 -> NACK, go to FAIL.
//  WAIT_IDLE: wait until synchronized clk=1 and data=1 in the same cycle.
//   Then pulse tx_done, go to IDLE, tx_ready=1 in the following cycle.
//  Timeout: the watchdog counter clears on INHIBIT exit and on every fall.
//   If it reaches TIMEOUT_CYCLES in RTS, SHIFT, ACK or WAIT_IDLE, go to FAIL.
//  FAIL: release both lines, pulse tx_err for one cycle, return to IDLE.
//  tx_done and tx_err are never asserted in the same cycle.
//  A fall seen in IDLE or INHIBIT is ignored; that traffic is device-to-host.
//  Latency, no stalls by device: tx_ready drops in the acceptance cycle; INHIBIT lasts INHIBIT_CYCLES.
// CONFIGURATION
//  PS2_TX_RETRY_EN defined:
//   - The first NACK or timeout of a byte does not pulse tx_err.
//   - The block re-enters INHIBIT and resends the latched byte once.
//   - A second failure goes to FAIL (tx_err). busy stays high throughout.
//  PS2_TX_RETRY_EN undefined: every failure goes straight to FAIL; there is no retry logic.
// TESTING  (bench: INHIBIT_CYCLES=100, TIMEOUT_CYCLES=5000, device model clock period 800 cycles)
//  1. Send 0xED, device ACKs.
//     -> clk_oe high for exactly 100 cycles; data bits read on device rising edges are 1,0,1,1,0,1,1,1,
//        then parity 1, stop 1; tx_done pulses once; tx_err stays 0.
//  2. Send 0xF4 -> parity bit 0; tx_done pulses. Send 0x00 -> parity bit 1; tx_done pulses.
//  3. Device answers NACK (data=1 in the ACK slot).
//     -> without macro, tx_err pulses and tx_ready=1 next cycle.
//     -> with PS2_TX_RETRY_EN, a second complete frame is sent, then tx_err.
//  4. Device stops clocking after bit 3.
//     -> tx_err exactly 5000 cycles after the last fall; clk_oe=data_oe=0 afterwards.
//  5. Assert rst during SHIFT (bitcnt=5) -> same cycle: clk_oe=data_oe=0, busy=0, tx_ready=1.
//  6. Hold tx_valid high with 0xFF for two back-to-back bytes.
//     -> second byte accepted only the cycle after the first tx_done; fall in IDLE ignored.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain clock/data enables.
// Optional macro PS2_TX_RETRY_EN: resend the latched byte once after a NACK or timeout.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       clk_oe,
  output logic       data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE, S_FAIL
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [8:0]             frame_q, frame_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   tx_ready_q, tx_ready_d, clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic                   busy_q, busy_d, tx_done_q, tx_done_d, tx_err_q, tx_err_d;
`ifdef PS2_TX_RETRY_EN
  logic                   retry_q, retry_d;
`endif
  logic                   clk_s, data_s, fall_c, timeout_c, fail_c;

  assign clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
  assign data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
  assign clk_s       = clk_sync_q[SYNC_STAGES-1];
  assign data_s      = data_sync_q[SYNC_STAGES-1];
  assign clk_prev_d  = clk_s;
  assign fall_c      = clk_prev_q & ~clk_s;

  assign tx_ready = tx_ready_q;
  assign clk_oe   = clk_oe_q;
  assign data_oe  = data_oe_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;
  assign tx_err   = tx_err_q;

  // Line synchronizers reset to the idle-high bus level so reset never fakes a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      frame_q     <= '0;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      tx_ready_q  <= 1'b1;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_err_q    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      frame_q     <= frame_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      tx_ready_q  <= tx_ready_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
      tx_err_q    <= tx_err_d;
`ifdef PS2_TX_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    frame_d   = frame_q;
    data_oe_d = data_oe_q;
    tx_done_d = 1'b0;
    tx_err_d  = 1'b0;
    fail_c    = 1'b0;
    timeout_c = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    // Shared counter: inhibit length in INHIBIT, fall-to-fall watchdog once the device clocks.
    if (state_q inside {S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE}) begin
      cnt_d     = fall_c ? '0 : cnt_q + CNT_W'(1);
      timeout_c = !fall_c && (cnt_q == TO_LAST);
    end

    case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready_q) begin
          frame_d = {~^tx_data, tx_data};
          cnt_d   = '0;
          state_d = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d = 1'b0;
`endif
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RTS: begin
        if (fall_c) begin
          data_oe_d = ~frame_q[0];
          bitcnt_d  = 4'd1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (fall_c) begin
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end else begin
            data_oe_d = ~frame_q[bitcnt_q];
          end
        end
      end
      S_ACK: begin
        data_oe_d = 1'b0;
        if (fall_c) begin
          if (data_s) fail_c = 1'b1;
          else        state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          tx_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_FAIL: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout_c && !tx_done_d) fail_c = 1'b1;

    if (fail_c) begin
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        retry_d   = 1'b1;
        cnt_d     = '0;
        data_oe_d = 1'b0;
        state_d   = S_INHIBIT;
      end else begin
        data_oe_d = 1'b0;
        tx_err_d  = 1'b1;
        state_d   = S_FAIL;
      end
`else
      data_oe_d = 1'b0;
      tx_err_d  = 1'b1;
      state_d   = S_FAIL;
`endif
    end

    // Ready is held off during the done pulse so a waiting byte starts one cycle later.
    clk_oe_d   = (state_d == S_INHIBIT);
    busy_d     = (state_d != S_IDLE);
    tx_ready_d = (state_d == S_IDLE) && !tx_done_d;
  end

endmodule
